// File: rtl/wacc_pkg.sv
// Shared types and constants for the window accumulator.
// Defines the FSM state type, the default window geometry and the closing-sample test.
package wacc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam int WIDTH_DEF    = 32;
    localparam int WIN_LOG2_DEF = 3;
    localparam int WIN_LEN      = 1 << WIN_LOG2_DEF;
    localparam int ACC_W        = WIDTH_DEF + WIN_LOG2_DEF;

    // True when a sample accepted at this count is the last one of a full window.
    function automatic logic win_last(input logic [8:0] cnt, input int win_log2);
        return cnt == 9'((1 << win_log2) - 1);
    endfunction

endpackage

// File: rtl/wacc_out_slot.sv
// Single-entry output holding register with valid/ready handshake.
// With WACC_AVERAGE_EN defined it also produces out_avg, one extra cycle after loading.
module wacc_out_slot
    import wacc_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int WIN_LOG2 = 3,
    localparam int ACC_W   = WIDTH + WIN_LOG2,
    localparam int CNT_W   = WIN_LOG2 + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [ACC_W-1:0] load_sum,
    input  logic [CNT_W-1:0] load_cnt,
    input  logic             out_ready,
    output logic             slot_free,
    output logic             out_valid,
    output logic [ACC_W-1:0] out_sum,
`ifdef WACC_AVERAGE_EN
    output logic [WIDTH-1:0] out_avg,
`endif
    output logic [CNT_W-1:0] out_cnt
);

`ifdef WACC_AVERAGE_EN
    localparam int SLOT_WIN = 1 << WIN_LOG2;

    logic             pending;
    logic [WIDTH-1:0] avg_calc;

    // A loaded window waits one cycle in the slot while its average settles.
    assign slot_free = !pending && (!out_valid || out_ready);

    // Full windows divide by shifting; partial ones pick among constant dividers.
    always_comb begin
        avg_calc = '0;
        if (out_cnt == CNT_W'(SLOT_WIN)) begin
            avg_calc = WIDTH'(out_sum >> WIN_LOG2);
        end else begin
            for (int k = 1; k < SLOT_WIN; k++) begin
                if (out_cnt == CNT_W'(k)) begin
                    avg_calc = WIDTH'(out_sum / ACC_W'(k));
                end
            end
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            pending   <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cnt   <= '0;
            out_avg   <= '0;
        end else if (load) begin
            pending   <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= load_sum;
            out_cnt   <= load_cnt;
        end else if (pending) begin
            pending   <= 1'b0;
            out_valid <= 1'b1;
            out_avg   <= avg_calc;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
`else
    assign slot_free = !out_valid || out_ready;

    always_ff @(negedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cnt   <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_sum   <= load_sum;
            out_cnt   <= load_cnt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/window_accumulator.sv
// Sums windows of 2**WIN_LOG2 accepted samples (or fewer on flush) into a held output.
// Optional feature macro: WACC_AVERAGE_EN adds out_avg and one cycle of output latency.
module window_accumulator
    import wacc_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int WIN_LOG2 = 3,
    localparam int ACC_W   = WIDTH + WIN_LOG2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    output logic              in_ready,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
`ifdef WACC_AVERAGE_EN
    output logic [WIDTH-1:0]  out_avg,
`endif
    output logic [WIN_LOG2:0] out_cnt
);

    localparam int CNT_W = WIN_LOG2 + 1;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic [ACC_W-1:0] sum_next;
    logic [CNT_W-1:0] cnt_next;
    logic             close;
    logic             slot_free;
    logic             load;
    logic [ACC_W-1:0] load_sum;
    logic [CNT_W-1:0] load_cnt;

    // A sample arriving with a flush counts toward the non-empty test.
    always_comb begin
        accept   = in_valid && in_ready;
        sum_next = acc + (accept ? ACC_W'(in_data) : ACC_W'(0));
        cnt_next = cnt + CNT_W'(accept);
        close    = (state == ACCUM) &&
                   ((accept && win_last(9'(cnt), WIN_LOG2)) ||
                    (flush && (cnt_next != '0)));
        load     = 1'b0;
        load_sum = '0;
        load_cnt = '0;
        if (state == ACCUM && close && slot_free) begin
            load     = 1'b1;
            load_sum = sum_next;
            load_cnt = cnt_next;
        end else if (state == STALL && slot_free) begin
            load     = 1'b1;
            load_sum = acc;
            load_cnt = cnt;
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            state    <= ACCUM;
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b1;
        end else begin
            unique case (state)
                ACCUM: begin
                    if (close && slot_free) begin
                        acc <= '0;
                        cnt <= '0;
                    end else if (close) begin
                        // Park the finished sum in acc until the slot drains.
                        acc      <= sum_next;
                        cnt      <= cnt_next;
                        state    <= STALL;
                        in_ready <= 1'b0;
                    end else if (accept) begin
                        acc <= sum_next;
                        cnt <= cnt_next;
                    end
                end
                STALL: begin
                    if (slot_free) begin
                        acc      <= '0;
                        cnt      <= '0;
                        state    <= ACCUM;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

    wacc_out_slot #(
        .WIDTH    (WIDTH),
        .WIN_LOG2 (WIN_LOG2)
    ) u_out_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_sum  (load_sum),
        .load_cnt  (load_cnt),
        .out_ready (out_ready),
        .slot_free (slot_free),
        .out_valid (out_valid),
        .out_sum   (out_sum),
`ifdef WACC_AVERAGE_EN
        .out_avg   (out_avg),
`endif
        .out_cnt   (out_cnt)
    );

endmodule

// File: tb/tb_window_accumulator.sv
// Testbench for window_accumulator: directed scenarios plus a randomized run,
// scored against a queue-based model of completed windows.
module tb_window_accumulator;

    localparam int WIDTH    = 32;
    localparam int WIN_LOG2 = 3;
    localparam int ACC_W    = WIDTH + WIN_LOG2;
    localparam int WIN      = 1 << WIN_LOG2;
`ifdef WACC_AVERAGE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [WIDTH-1:0]  in_data;
    logic              in_ready;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [WIN_LOG2:0] out_cnt;
`ifdef WACC_AVERAGE_EN
    logic [WIDTH-1:0]  out_avg;
`endif

    int checks = 0;
    int errors = 0;

    logic [63:0] q_sum[$];
    int          q_cnt[$];
    logic [63:0] m_sum = '0;
    int          m_cnt = 0;

    always #5 clk = ~clk;

    window_accumulator #(
        .WIDTH    (WIDTH),
        .WIN_LOG2 (WIN_LOG2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
`ifdef WACC_AVERAGE_EN
        .out_avg   (out_avg),
`endif
        .out_cnt   (out_cnt)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One falling clock edge: score consumed outputs, update the window model, advance.
    task automatic tick();
        logic        acc_now;
        logic        cons_now;
        logic        hold_now;
        logic [63:0] held_sum;
        acc_now  = !rst && in_valid && in_ready;
        cons_now = !rst && out_valid && out_ready;
        hold_now = !rst && out_valid && !out_ready;
        held_sum = 64'(out_sum);
        if (cons_now) begin
            checkOutput("sb_expected_window", 64'(q_sum.size() != 0), 64'(1));
            if (q_sum.size() != 0) begin
                checkOutput("sb_sum", 64'(out_sum), q_sum[0]);
                checkOutput("sb_cnt", 64'(out_cnt), 64'(q_cnt[0]));
`ifdef WACC_AVERAGE_EN
                checkOutput("sb_avg", 64'(out_avg), q_sum[0] / 64'(q_cnt[0]));
`endif
                void'(q_sum.pop_front());
                void'(q_cnt.pop_front());
            end
        end
        if (rst) begin
            q_sum.delete();
            q_cnt.delete();
            m_sum = '0;
            m_cnt = 0;
        end else if (in_ready) begin
            if (acc_now) begin
                m_sum += 64'(in_data);
                m_cnt++;
            end
            if (m_cnt == WIN || (flush && m_cnt != 0)) begin
                q_sum.push_back(m_sum);
                q_cnt.push_back(m_cnt);
                m_sum = '0;
                m_cnt = 0;
            end
        end
        @(negedge clk);
        #1;
        if (hold_now && !rst) checkOutput("hold_stable", 64'(out_sum), held_sum);
    endtask

    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic f, input logic r);
        in_valid  = v;
        in_data   = d;
        flush     = f;
        out_ready = r;
        tick();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [63:0] sum_a;
        logic [63:0] sum_b;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] held;
        int guard;

        in_valid = 0; in_data = '0; flush = 0; out_ready = 0; rst = 1;
        repeat (2) tick();
        rst = 0;
        checkOutput("reset_out_valid", 64'(out_valid), 64'(0));
        checkOutput("reset_in_ready", 64'(in_ready), 64'(1));
        checkOutput("reset_out_sum", 64'(out_sum), 64'(0));
        checkOutput("reset_out_cnt", 64'(out_cnt), 64'(0));

        // Full window 1..8.
        for (int i = 1; i <= WIN; i++) begin
            applyStimulus(1, WIDTH'(i), 0, 1);
            if (i == WIN - 1) checkOutput("t1_no_early_valid", 64'(out_valid), 64'(0));
        end
        repeat (LAT - 1) applyStimulus(0, '0, 0, 0);
        checkOutput("t1_valid", 64'(out_valid), 64'(1));
        checkOutput("t1_sum", 64'(out_sum), 64'd36);
        checkOutput("t1_cnt", 64'(out_cnt), 64'd8);
`ifdef WACC_AVERAGE_EN
        checkOutput("t1_avg", 64'(out_avg), 64'd4);
`endif
        applyStimulus(0, '0, 0, 1);
        checkOutput("t1_drained", 64'(out_valid), 64'(0));

        // Maximum samples: no overflow at ACC_W.
        for (int i = 0; i < WIN; i++) applyStimulus(1, 32'hFFFF_FFFF, 0, 1);
        repeat (LAT - 1) applyStimulus(0, '0, 0, 0);
        checkOutput("t2_sum", 64'(out_sum), 64'h7_FFFF_FFF8);
        checkOutput("t2_cnt", 64'(out_cnt), 64'd8);
        applyStimulus(0, '0, 0, 1);

        // Back-pressure: second window stalls behind the first.
        sum_a = '0;
        sum_b = '0;
        for (int i = 0; i < WIN; i++) begin
            d = $urandom;
            sum_a += 64'(d);
            applyStimulus(1, d, 0, 0);
        end
        repeat (LAT - 1) applyStimulus(0, '0, 0, 0);
        checkOutput("t3_first_valid", 64'(out_valid), 64'(1));
        checkOutput("t3_first_sum", 64'(out_sum), sum_a);
        for (int i = 0; i < WIN; i++) begin
            d = $urandom;
            sum_b += 64'(d);
            applyStimulus(1, d, 0, 0);
            if (i == WIN - 2) checkOutput("t3_ready_before_close", 64'(in_ready), 64'(1));
        end
        checkOutput("t3_ready_dropped", 64'(in_ready), 64'(0));
        held = $urandom;
        repeat (3) applyStimulus(1, held, 0, 0);
        checkOutput("t3_stall_ready", 64'(in_ready), 64'(0));
        checkOutput("t3_first_held", 64'(out_sum), sum_a);
        applyStimulus(1, held, 0, 1);
        repeat (LAT - 1) applyStimulus(0, '0, 0, 0);
        checkOutput("t3_second_valid", 64'(out_valid), 64'(1));
        checkOutput("t3_second_sum", 64'(out_sum), sum_b);
        checkOutput("t3_ready_back", 64'(in_ready), 64'(1));
        applyStimulus(1, held, 0, 1);
        applyStimulus(0, '0, 1, 1);
        repeat (LAT) applyStimulus(0, '0, 0, 1);
        checkOutput("t3_all_delivered", 64'(q_sum.size()), 64'(0));

        // Partial window closed by flush, then an empty flush.
        applyStimulus(1, 32'd10, 0, 1);
        applyStimulus(1, 32'd20, 0, 1);
        applyStimulus(1, 32'd30, 0, 1);
        applyStimulus(0, '0, 1, 1);
        repeat (LAT - 1) applyStimulus(0, '0, 0, 0);
        checkOutput("t4_valid", 64'(out_valid), 64'(1));
        checkOutput("t4_sum", 64'(out_sum), 64'd60);
        checkOutput("t4_cnt", 64'(out_cnt), 64'd3);
        applyStimulus(0, '0, 1, 1);
        checkOutput("t4_empty_flush_now", 64'(out_valid), 64'(0));
        repeat (LAT) applyStimulus(0, '0, 0, 1);
        checkOutput("t4_empty_flush_later", 64'(out_valid), 64'(0));

        applyStimulus(1, 32'd3, 0, 1);
        applyStimulus(1, 32'd6, 0, 1);
        applyStimulus(1, 32'd9, 0, 1);
        applyStimulus(0, '0, 1, 1);
        repeat (LAT - 1) applyStimulus(0, '0, 0, 0);
        checkOutput("t4b_sum", 64'(out_sum), 64'd18);
`ifdef WACC_AVERAGE_EN
        checkOutput("t4b_avg", 64'(out_avg), 64'd6);
`endif
        applyStimulus(0, '0, 0, 1);

        // Flush together with the first sample.
        applyStimulus(1, 32'd5, 1, 1);
        repeat (LAT - 1) applyStimulus(0, '0, 0, 0);
        checkOutput("t5_valid", 64'(out_valid), 64'(1));
        checkOutput("t5_sum", 64'(out_sum), 64'd5);
        checkOutput("t5_cnt", 64'(out_cnt), 64'd1);
        applyStimulus(0, '0, 0, 1);

        // Reset while stalled discards everything.
        for (int i = 0; i < 2 * WIN; i++) applyStimulus(1, $urandom, 0, 0);
        checkOutput("t6_stalled", 64'(in_ready), 64'(0));
        rst = 1;
        applyStimulus(0, '0, 0, 0);
        rst = 0;
        checkOutput("t6_out_valid", 64'(out_valid), 64'(0));
        checkOutput("t6_in_ready", 64'(in_ready), 64'(1));
        sum_a = '0;
        for (int i = 0; i < WIN; i++) begin
            d = $urandom;
            sum_a += 64'(d);
            applyStimulus(1, d, 0, 1);
        end
        repeat (LAT - 1) applyStimulus(0, '0, 0, 0);
        checkOutput("t6_fresh_sum", 64'(out_sum), sum_a);
        applyStimulus(0, '0, 0, 1);

        // Randomized traffic against the window model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom,
                          $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
        end
        applyStimulus(0, '0, 1, 1);
        guard = 0;
        while ((q_sum.size() != 0 || out_valid) && guard < 20) begin
            applyStimulus(0, '0, 0, 1);
            guard++;
        end
        checkOutput("rand_drained_queue", 64'(q_sum.size()), 64'(0));
        checkOutput("rand_drained_valid", 64'(out_valid), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
